obc_da_dft_bin: RTL

- Bit-serial offset-binary-coded (OBC) distributed-arithmetic engine. Computes one DFT output component: real or imaginary, optionally sign-inverted.
- Replaces the fixed, fully combinational 16-input ROM/sign-fold/adder slice with a parametrised, sequential unit. Lookup tables are programmable, the input count and width are generic, and it accumulates one bit plane per clock, MSB first.
- Sits between the sample buffer and the DFT output register bank. One instance per bin component.

---
 rtl/obc_da_dft_bin.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/obc_da_dft_bin.sv
// Bit-serial offset-binary-coded distributed-arithmetic slice for one DFT bin component.
// Each cycle folds one input bit plane (MSB first) through programmable group tables into a shift-accumulator.
module obc_da_dft_bin #(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 8,
    parameter int GRP    = 4,
    parameter int COEF_W = 16,
    localparam int NGRP  = NUM_IN / GRP,
    localparam int AW    = $clog2(NGRP) + GRP - 1,
    localparam int OFF_W = COEF_W + $clog2(NUM_IN),
    localparam int ACC_W = COEF_W + DATA_W + $clog2(NUM_IN) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic [NUM_IN*DATA_W-1:0]   x_in,
    input  logic                       cfg_we,
    input  logic [AW-1:0]              cfg_addr,
    input  logic [COEF_W-1:0]          cfg_data,
    input  logic                       off_we,
    input  logic [OFF_W-1:0]           off_data,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           result
);

    localparam int TBL_D = 1 << (GRP - 1);
    localparam int PW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (NUM_IN % GRP != 0) begin : g_bad_grp
        $error("NUM_IN must be an integer multiple of GRP");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OFFS = 2'd2
    } state_t;

    state_t state, state_d;

    logic [COEF_W-1:0]       tbl [2**AW];
    logic [OFF_W-1:0]        off_q;
    logic [DATA_W-1:0]       xs [NUM_IN];
    logic                    mode_q;
    logic [PW-1:0]           plane;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] d_sum;
    logic signed [ACC_W-1:0] off_term;
    logic signed [ACC_W-1:0] acc_final;
    logic [NUM_IN-1:0]       plane_bits;
    logic [GRP-2:0]          addr_g [NGRP];
    logic [NGRP-1:0]         neg_g;
    logic [COEF_W-1:0]       ent_g [NGRP];
    logic signed [ACC_W-1:0] p_g [NGRP];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (plane == '0) state_d = OFFS;
            OFFS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        plane_bits = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            plane_bits[k] = xs[k][plane];
        end
    end

    // The first sample of a group selects the sign fold; the others, flipped by it, address the half-size table.
    always_comb begin
        d_sum = '0;
        neg_g = '0;
        for (int g = 0; g < NGRP; g++) begin
            addr_g[g] = '0;
            for (int j = 1; j < GRP; j++) begin
                addr_g[g][j-1] = plane_bits[g*GRP+j] ^ plane_bits[g*GRP];
            end
            neg_g[g] = plane_bits[g*GRP] ^ mode_q;
            ent_g[g] = tbl[AW'(g*TBL_D) + AW'(addr_g[g])];
            p_g[g]   = {{(ACC_W-COEF_W){ent_g[g][COEF_W-1]}}, ent_g[g]};
            if (neg_g[g]) begin
                p_g[g] = -p_g[g];
            end
            d_sum = d_sum + p_g[g];
        end
    end

    always_comb begin
        off_term = {{(ACC_W-OFF_W){off_q[OFF_W-1]}}, off_q};
        if (mode_q) begin
            off_term = -off_term;
        end
        acc_final = acc + off_term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                tbl[i] <= '0;
            end
            for (int k = 0; k < NUM_IN; k++) begin
                xs[k] <= '0;
            end
            off_q  <= '0;
            mode_q <= 1'b0;
            plane  <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        tbl[cfg_addr] <= cfg_data;
                    end
                    if (off_we) begin
                        off_q <= off_data;
                    end
                    if (start) begin
                        for (int k = 0; k < NUM_IN; k++) begin
                            xs[k] <= x_in[k*DATA_W +: DATA_W];
                        end
                        mode_q <= mode;
                        plane  <= PW'(DATA_W - 1);
                    end
                end
                // The MSB plane carries negative weight in two's complement, hence the negated seed.
                RUN: begin
                    if (plane == PW'(DATA_W - 1)) begin
                        acc <= -d_sum;
                    end else begin
                        acc <= (acc <<< 1) + d_sum;
                    end
                    if (plane != '0) begin
                        plane <= plane - 1'b1;
                    end
                end
                OFFS: begin
                    result <= acc_final;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
